// File: rtl/fifo_to_com_if.sv
// FIFO read port, frame control and COM tx signals of the fifo_to_com block.
// The slave modport is the block itself; the master modport is whatever drives it.
interface fifo_to_com_if;
  logic       enable;
  logic       start;
  logic [7:0] byte_count;
  logic       fifo_empty;
  logic [7:0] fifo_data_in;
  logic       fifo_re;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] crc;

  modport master (
    output enable, start, byte_count, fifo_empty, fifo_data_in,
    input  fifo_re, tx, busy, done, crc
  );

  modport slave (
    input  enable, start, byte_count, fifo_empty, fifo_data_in,
    output fifo_re, tx, busy, done, crc
  );
endinterface

// File: rtl/fifo_to_com.sv
// fifo_to_com: drains byte_count bytes from the shared FIFO, sends each one
// as UART 8N1 on tx, and finishes the frame with a CRC-8 trailer byte.
// The CRC runs bit-serially, MSB first, during each payload byte's start bit.
module fifo_to_com #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] CRC_POLY     = 8'h07,
  parameter logic [7:0] CRC_INIT     = 8'h00
) (
  input logic          clk,
  input logic          reset,
  fifo_to_com_if.slave bus
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, SEND_CRC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       remaining;
  logic [7:0]       shreg;
  logic [7:0]       crc_data;
  logic [7:0]       crc;
  logic [3:0]       crc_cnt;
  logic             tx_r;
  logic             fifo_re;
  logic             accept;
  logic             bit_end;
  logic             frame_end;

  // One MSB-first CRC step: feedback is the CRC MSB xor the incoming bit.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[7] ^ d;
    return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  // Next-state decode and the FIFO read strobe.
  always_comb begin
    state_nxt = state;
    fifo_re   = 1'b0;
    accept    = bus.start && bus.enable;
    bit_end   = (clk_cnt == LAST_CLK);
    frame_end = bit_end && (bit_cnt == 4'd9);
    case (state)
      IDLE:     if (accept) state_nxt = (bus.byte_count == 8'd0) ? SEND_CRC : FETCH;
      FETCH:    if (!bus.fifo_empty) begin
                  fifo_re   = 1'b1;
                  state_nxt = CAPTURE;
                end
      CAPTURE:  state_nxt = SHIFT;
      SHIFT:    if (frame_end) state_nxt = (remaining != 8'd0) ? FETCH : SEND_CRC;
      SEND_CRC: if (frame_end) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bit timing, tx line, byte counter and the CRC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_r      <= 1'b1;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      remaining <= '0;
      crc       <= CRC_INIT;
      crc_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (accept) begin
            remaining <= bus.byte_count;
            crc       <= CRC_INIT;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            // An empty frame goes straight to the trailer start bit.
            if (bus.byte_count == 8'd0) tx_r <= 1'b0;
          end
        end
        CAPTURE: begin
          remaining <= remaining - 8'd1;
          crc_cnt   <= 4'd8;
          tx_r      <= 1'b0;
          clk_cnt   <= '0;
          bit_cnt   <= '0;
        end
        SHIFT, SEND_CRC: begin
          // The trailer carries the CRC, so only payload bytes feed it.
          if (state == SHIFT && crc_cnt != 4'd0) begin
            crc     <= crc_step(crc, crc_data[7]);
            crc_cnt <= crc_cnt - 4'd1;
          end
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) tx_r <= shreg[bit_cnt[2:0]];
            else                tx_r <= 1'b1;
            // Last payload byte runs directly into the trailer start bit.
            if (frame_end && state == SHIFT && remaining == 8'd0) begin
              tx_r    <= 1'b0;
              bit_cnt <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: tx_r <= 1'b1;
      endcase
    end
  end

  // Byte shift register and CRC feed copy; pure data, no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE:    if (accept) shreg <= CRC_INIT;
      CAPTURE: begin
        shreg    <= bus.fifo_data_in;
        crc_data <= bus.fifo_data_in;
      end
      SHIFT: begin
        if (crc_cnt != 4'd0) crc_data <= {crc_data[6:0], 1'b0};
        // CRC has settled long before the stop bit ends; load it for the trailer.
        if (frame_end) shreg <= crc;
      end
      default: ;
    endcase
  end

  assign bus.fifo_re = fifo_re;
  assign bus.tx      = tx_r;
  assign bus.busy    = state inside {FETCH, CAPTURE, SHIFT, SEND_CRC};
  assign bus.done    = (state == DONE);
  assign bus.crc     = crc;

endmodule

// File: doc/fifo_to_com.md
Name: fifo_to_com

Overview:
- Downstream counterpart of the UART-receive/FIFO-write stage. Drains a requested number of bytes from the shared byte FIFO and serialises each one onto the UART tx line as 8N1.
- Runs a bitwise CRC-8 over every transmitted byte, then appends the CRC as a trailer byte.
- Sits between the FIFO read port and the board's COM tx pin, and closes the PC→FPGA→PC loop.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be >= 16.
- CRC_POLY, 8'h07, CRC-8 generator polynomial (x^8+x^2+x+1).
- CRC_INIT, 8'h00, CRC register value at start of each frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  gates acceptance of start; has no effect on a frame in progress.
- start  input  1  one-cycle pulse; begins a frame when in IDLE.
- byte_count  input  8  payload bytes to send; sampled on the accepted start.
- fifo_empty  input  1  FIFO has no data.
- fifo_data_in  input  8  FIFO read data; valid the cycle after fifo_re.
- fifo_re  output  1  one-cycle FIFO read strobe.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse after the CRC stop bit.
- CRC  output  8  running CRC; holds its final value after done until the next start.

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, fifo_re=0, busy=0, done=0, CRC=CRC_INIT, counters=0. A reset mid-frame forces tx high immediately, truncating the frame.
- UART format: start bit (0), data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles, so one byte takes 10*CLKS_PER_BIT cycles. tx is a registered output.
- CRC: MSB-first bit-serial. Per bit: fb = CRC[7]^d; CRC = {CRC[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Eight update cycles run immediately after each payload byte is captured, overlapping that byte's start bit.
  - The CRC trailer byte does not update CRC.
- FSM:
  - IDLE: on start&&enable, latch byte_count into remaining, set CRC=CRC_INIT, busy=1. If byte_count==0, go to SEND_CRC; else go to FETCH. start is ignored while busy or while enable=0.
  - FETCH: wait while fifo_empty=1, keeping tx=1 with no timeout. When fifo_empty=0, pulse fifo_re for 1 cycle and go to CAPTURE.
  - CAPTURE: latch fifo_data_in into the shift register, decrement remaining, go to SHIFT.
  - SHIFT: transmit the 10-bit frame while the bit-serial CRC runs in parallel. On the stop bit's last cycle, go to FETCH if remaining!=0, else SEND_CRC.
  - SEND_CRC: transmit the current CRC value as a normal 8N1 byte, then go to DONE.
  - DONE: done=1 and busy=0 for 1 cycle, return to IDLE.
- Minimum gap between payload frames is 2 idle-high cycles (FETCH+CAPTURE) when the FIFO is non-empty.
- fifo_re is never asserted while fifo_empty=1, and at most once per payload byte.
- A start pulse coinciding with done is ignored; the FSM accepts start only from IDLE, one cycle later.
- byte_count=0: no FIFO reads; transmits a single trailer byte equal to CRC_INIT.

Test Plan:
- Reset, then idle 100 cycles → tx=1, busy=0, fifo_re never pulses, CRC=0x00.
- CLKS_PER_BIT=16; FIFO preloaded "123456789" (0x31..0x39); start with byte_count=9 → 9 fifo_re pulses, tx decodes 0x31..0x39 then 0xF4, CRC=0xF4, done pulses once.
- byte_count=1, FIFO={0x01} → tx bytes 0x01 then 0x07; single byte 0x80 → 0x80 then 0x89. Each frame is 160 cycles with the start bit low for exactly 16 cycles.
- byte_count=2 with FIFO empty; push bytes 500 cycles later → tx stays high and fifo_re stays 0 until fifo_empty falls, then normal transmission, busy held throughout.
- Pulse start while busy, and also with enable=0 in IDLE → both ignored. byte_count=0 → one 0x00 trailer byte, no fifo_re.
- Assert reset during data bit 3 of the second byte → tx=1 and busy=0 within the same cycle. A new start after release sends a full correct frame with CRC restarted from 0x00.
